// File: rtl/tanh_grad_bwd.sv
`default_nettype none
// ============================================================================
// Module      : tanh_grad_bwd
// Description : tanh backward pass, dx = g * (1 - y^2), 3-stage valid/ready pipe.
//               Optional macro TANH_GRAD_RND_EN: round-half-up on both shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module tanh_grad_bwd #(
    parameter int FRAC = 9,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] g_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dx_out,
    output logic [15:0]  out_count
);

`ifdef TANH_GRAD_RND_EN
    localparam int c_RND = 1;
`else
    localparam int c_RND = 0;
`endif

    localparam int                    c_ONE     = 1 << FRAC;
    localparam logic signed [W-1:0]   c_POS_ONE = W'(c_ONE);
    localparam logic signed [W-1:0]   c_NEG_ONE = W'(-c_ONE);
    localparam logic [W:0]            c_ONE_D   = (W+1)'(c_ONE);
    localparam logic [2*W-1:0]        c_HALF_S  = (2*W)'(c_RND) << (FRAC-1);
    localparam logic signed [2*W+1:0] c_HALF_P  = (2*W+2)'(c_RND) << (FRAC-1);
    localparam logic signed [2*W+1:0] c_QMAX    = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W+1:0] c_QMIN    = {{(W+3){1'b1}}, {(W-1){1'b0}}};

    logic                    r_v1_q, r_v2_q, r_v3_q;
    logic signed [W-1:0]     r_yc_q;
    logic [W-1:0]            r_g1_q, r_g2_q;
    logic [W:0]              r_d2_q;
    logic [W-1:0]            r_dx_q;
    logic [15:0]             r_cnt_q;

    logic                    w_advance;
    logic signed [W-1:0]     w_y;
    logic signed [W-1:0]     w_yc_d;
    logic signed [2*W-1:0]   w_sq;
    logic [2*W-1:0]          w_sq_r;
    logic [W:0]              w_d_d;
    logic signed [2*W+1:0]   w_g_ext, w_d_ext, w_p, w_pr, w_q;
    logic [W-1:0]            w_dx_d;
    logic                    w_unused;

    assign w_advance = ~(r_v3_q & ~out_ready);
    assign in_ready  = w_advance;
    assign out_valid = r_v3_q;
    assign dx_out    = r_dx_q;
    assign out_count = r_cnt_q;

    // Stage 1: clamp the stored activation to the legal tanh range.
    assign w_y    = $signed(y_in);
    assign w_yc_d = (w_y > c_POS_ONE) ? c_POS_ONE :
                    (w_y < c_NEG_ONE) ? c_NEG_ONE : w_y;

    // Stage 2: d = ONE - y^2; |y_c| <= ONE keeps s within 0..ONE.
    assign w_sq     = r_yc_q * r_yc_q;
    assign w_sq_r   = $unsigned(w_sq) + c_HALF_S;
    assign w_d_d    = c_ONE_D - w_sq_r[FRAC +: W+1];
    assign w_unused = ^{w_sq_r[2*W-1:FRAC+W+1], w_sq_r[FRAC-1:0]};

    // Stage 3: signed g times non-negative d, shift, then saturate.
    assign w_g_ext = {{(W+2){r_g2_q[W-1]}}, r_g2_q};
    assign w_d_ext = {{(W+1){1'b0}}, r_d2_q};
    assign w_p     = w_g_ext * w_d_ext;
    assign w_pr    = w_p + c_HALF_P;
    assign w_q     = w_pr >>> FRAC;
    assign w_dx_d  = (w_q > c_QMAX) ? c_QMAX[W-1:0] :
                     (w_q < c_QMIN) ? c_QMIN[W-1:0] : w_q[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1_q  <= 1'b0;
            r_v2_q  <= 1'b0;
            r_v3_q  <= 1'b0;
            r_dx_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            if (w_advance) begin
                r_v1_q <= in_valid;
                r_v2_q <= r_v1_q;
                r_v3_q <= r_v2_q;
                if (r_v2_q) begin
                    r_dx_q <= w_dx_d;
                end
            end
            if (r_v3_q && out_ready) begin
                r_cnt_q <= r_cnt_q + 16'd1;
            end
        end
    end

    // Datapath payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            if (in_valid) begin
                r_yc_q <= w_yc_d;
                r_g1_q <= g_in;
            end
            if (r_v1_q) begin
                r_d2_q <= w_d_d;
                r_g2_q <= r_g1_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tanh_grad_bwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_tanh_grad_bwd
// Description : Scoreboard bench for tanh_grad_bwd (directed + random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tanh_grad_bwd;
    localparam int W    = 16;
    localparam int FRAC = 9;
    localparam int ONE  = 1 << FRAC;
`ifdef TANH_GRAD_RND_EN
    localparam int HALF = ONE / 2;
    localparam int NEAR_SAT_EXP = 640;
`else
    localparam int HALF = 0;
    localparam int NEAR_SAT_EXP = 639;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] g_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] dx_out;
    logic [15:0]  out_count;

    int n_checks = 0;
    int n_errors = 0;
    int q_exp[$];
    bit stop_rdy;

    tanh_grad_bwd #(.FRAC(FRAC), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y_in(y_in), .g_in(g_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .dx_out(dx_out), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Reference: dx = g * (1 - y^2) in real-valued terms, quantised by floor.
    function automatic int model(input int y, input int g);
        longint yc, s, d, q;
        yc = (y > ONE) ? ONE : (y < -ONE) ? -ONE : y;
        s  = floor_div(yc * yc + HALF, ONE);
        d  = ONE - s;
        q  = floor_div(longint'(g) * d + HALF, ONE);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // Monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got %0d expected none", $signed(dx_out));
            end else begin
                chk("dx_out", longint'($signed(dx_out)), longint'(q_exp.pop_front()));
            end
        end
    end

    task automatic send(input int y, input int g, input int exp);
        y_in     = y[W-1:0];
        g_in     = g[W-1:0];
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                q_exp.push_back(exp);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_exp.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (q_exp.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", q_exp.size(), 0);
    endtask

    // Called right after an accept edge k: result visible only after k+2.
    task automatic check_latency(input int exp);
        chk("lat_after_k", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_after_k1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_after_k2_valid", out_valid, 1);
        chk("lat_after_k2_dx", $signed(dx_out), exp);
    endtask

    initial begin
        int y, g;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Zero activation and latency
        out_ready = 1'b1;
        send(0, 256, 256);
        check_latency(256);
        @(posedge clk); #1;
        chk("count_after_first", out_count, 1);

        // Half scale, near saturation, clamping, extreme gradients
        send(256, 512, 384);
        send(-256, -512, -384);
        send(507, 32767, NEAR_SAT_EXP);
        send(1024, 1000, 0);
        send(-600, 1000, 0);
        send(0, -32768, -32768);
        send(0, 32767, 32767);
        send(512, -32768, 0);
        drain();
        chk("count_after_directed", out_count, 9);

        // Backpressure: four samples while the output is blocked
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) send(0, k, k);
            end
            begin
                repeat (3) @(negedge clk);
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_dx_hold", $signed(dx_out), 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_out_count", out_count, 4);

        // Reset with samples in flight
        do_reset();
        out_ready = 1'b1;
        send(0, 5, 5);
        drain();
        chk("pre_midrst_count", out_count, 1);
        send(0, 1, 1);
        send(0, 2, 2);
        send(0, 3, 3);
        do_reset();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_count", out_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        send(0, 7, 7);
        check_latency(7);
        drain();
        chk("post_midrst_count", out_count, 1);

        // Random traffic with random backpressure
        do_reset();
        stop_rdy = 1'b0;
        fork
            begin
                repeat (400) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 65535)) - 32768;
                    else                           y = int'($urandom_range(0, 1200)) - 600;
                    g = int'($urandom_range(0, 65535)) - 32768;
                    send(y, g, model(y, g));
                end
                stop_rdy = 1'b1;
            end
            begin
                while (!stop_rdy) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        chk("rand_out_count", out_count, 400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
